irq_ctrl: RTL



---
 rtl/irq_ctrl_if.sv | 12 +
 rtl/irq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Peripheral bus bundle for irq_ctrl: 8-bit byte address and single-cycle read/write strobes.
// The master side drives the request; rdata comes back combinationally from the slave.
interface irq_ctrl_if;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
  modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: latches peripheral requests and resolves fixed lowest-ID-wins priority.
// Firmware uses CLAIM/COMPLETE over the peripheral bus. Define IRQC_SYNC_EN to add a 2-flop input synchronizer.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_out
);

  localparam logic [2:0] REG_PENDING   = 3'd0;
  localparam logic [2:0] REG_ENABLE    = 3'd1;
  localparam logic [2:0] REG_TRIGGER   = 3'd2;
  localparam logic [2:0] REG_CLAIM     = 3'd3;
  localparam logic [2:0] REG_COMPLETE  = 3'd4;
  localparam logic [2:0] REG_SWSET     = 3'd5;
  localparam logic [2:0] REG_INSERVICE = 3'd6;

  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] trigger_q, trigger_d;
  logic [N_SRC-1:0] insvc_q, insvc_d;

  logic [N_SRC-1:0] claimable;
  logic [N_SRC-1:0] win_vec;
  logic [4:0]       win_id;
  logic [N_SRC-1:0] claim_vec;
  logic [N_SRC-1:0] complete_vec;
  logic [N_SRC-1:0] swset_vec;
  logic [N_SRC-1:0] set_vec;
  logic [2:0]       sel;
  logic             wr_enable, wr_trigger, wr_complete, wr_swset, rd_claim;
  logic [31:0]      rdata_c;
  logic             unused_addr;

  function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N_SRC-1:0] = v;
    return r;
  endfunction

`ifdef IRQC_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  always_comb src_d = sync2_q;
`else
  always_comb src_d = irq_src;
`endif

  assign sel         = bus.addr[4:2];
  assign unused_addr = ^{bus.addr[7:5], bus.addr[1:0]};
  assign wr_enable   = bus.wr_en && (sel == REG_ENABLE);
  assign wr_trigger  = bus.wr_en && (sel == REG_TRIGGER);
  assign wr_complete = bus.wr_en && (sel == REG_COMPLETE);
  assign wr_swset    = bus.wr_en && (sel == REG_SWSET);
  assign rd_claim    = bus.rd_en && (sel == REG_CLAIM);

  // Lowest set bit of the claimable set is the winner; scanning downward leaves the lowest ID last.
  always_comb begin
    claimable = pending_q & enable_q & ~insvc_q;
    win_vec   = '0;
    win_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (claimable[i]) begin
        win_vec    = '0;
        win_vec[i] = 1'b1;
        win_id     = 5'(i + 1);
      end
    end
  end

  always_comb begin
    claim_vec    = rd_claim ? win_vec : '0;
    swset_vec    = wr_swset ? bus.wdata[N_SRC-1:0] : '0;
    complete_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      complete_vec[i] = wr_complete && (bus.wdata == 32'(i + 1)) && insvc_q[i];
    end
  end

  // Level requests are masked while in service (and on the claim edge); edges and SWSET queue one event.
  always_comb begin
    src_prev_d = src_q;
    set_vec    = (trigger_q & src_q & ~src_prev_q)
               | (~trigger_q & src_q & ~insvc_q & ~claim_vec)
               | swset_vec;
    pending_d  = (pending_q & ~claim_vec) | set_vec;
    if (wr_trigger) begin
      pending_d = pending_d & ~(trigger_q ^ bus.wdata[N_SRC-1:0]);
    end
    insvc_d    = (insvc_q | claim_vec) & ~complete_vec;
    enable_d   = wr_enable ? bus.wdata[N_SRC-1:0] : enable_q;
    trigger_d  = wr_trigger ? bus.wdata[N_SRC-1:0] : trigger_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q      <= '0;
      src_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      trigger_q  <= '0;
      insvc_q    <= '0;
    end else begin
      src_q      <= src_d;
      src_prev_q <= src_prev_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      trigger_q  <= trigger_d;
      insvc_q    <= insvc_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    if (bus.rd_en) begin
      case (sel)
        REG_PENDING:   rdata_c = zext(pending_q);
        REG_ENABLE:    rdata_c = zext(enable_q);
        REG_TRIGGER:   rdata_c = zext(trigger_q);
        REG_CLAIM:     rdata_c = {27'd0, win_id};
        REG_INSERVICE: rdata_c = zext(insvc_q);
        default:       rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign irq_out   = |claimable;

endmodule
